// File: rtl/hyperbus_pkg.sv
// Shared definitions for the Hyperbus burst engine: FSM encodings, command
// direction constants and a constant-foldable ceil(log2) helper.
package hyperbus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_WRITE = 4'b0010,
        ST_READ  = 4'b0100,
        ST_DONE  = 4'b1000
    } hbus_state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hyperbus_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after rr_ptr, plus its binary index.
module hyperbus_rr_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int PTR_W = 1
) (
    input  logic [NCH-1:0]   req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NCH-1:0]   grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [PTR_W-1:0] idx_s;
    logic             hit_s;

    // Scan channels starting at rr_ptr; the first requester found wins.
    always_comb begin
        grant     = {NCH{1'b0}};
        grant_idx = {PTR_W{1'b0}};
        grant_any = 1'b0;
        idx_s     = {PTR_W{1'b0}};
        hit_s     = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx_s        = PTR_W'((int'(rr_ptr) + k) % NCH);
            hit_s        = req[idx_s] & ~grant_any;
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? idx_s : grant_idx;
            grant_any    = grant_any | hit_s;
        end
    end

endmodule

// File: rtl/hyperbus_burst_arbiter.sv
// Round-robin multi-channel burst engine: serialises user words into Hyperbus
// write beats and assembles read beats into user words via a 2-word buffer.
module hyperbus_burst_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NCH             = 2,
    parameter int WORD_WIDTH      = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH       = 8
) (
    input  logic                           hbus_clk,
    input  logic                           hbus_rst,
    input  logic [NCH-1:0]                 cmd_valid,
    output logic [NCH-1:0]                 cmd_ready,
    input  logic [NCH-1:0]                 cmd_we,
    input  logic [NCH*HBUS_ADDR_WIDTH-1:0] cmd_adr,
    input  logic [NCH*LEN_WIDTH-1:0]       cmd_len,
    input  logic [NCH-1:0]                 wr_valid,
    output logic [NCH-1:0]                 wr_ready,
    input  logic [NCH*WORD_WIDTH-1:0]      wr_dat,
    output logic [NCH-1:0]                 rd_valid,
    input  logic [NCH-1:0]                 rd_ready,
    output logic [WORD_WIDTH-1:0]          rd_dat,
    output logic [NCH-1:0]                 done,
    output logic [NCH-1:0]                 rd_overrun,
    output logic [HBUS_ADDR_WIDTH-1:0]     hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0]     hbus_dat_o,
    input  logic [HBUS_DATA_WIDTH-1:0]     hbus_dat_i,
    output logic                           hbus_rrq,
    output logic                           hbus_wrq,
    input  logic                           hbus_ready,
    input  logic                           hbus_valid,
    input  logic                           hbus_busy
);

    localparam int CYCLES = WORD_WIDTH / HBUS_DATA_WIDTH;
    localparam int PTR_W  = (NCH > 1) ? clog2(NCH) : 1;
    localparam int CYC_W  = clog2(CYCLES) + 1;
    localparam int BCNT_W = LEN_WIDTH + CYC_W;
    localparam int WCNT_W = LEN_WIDTH + 1;

    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NCH - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1'b1);
    localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1'b1);
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(CYCLES - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1'b1);

    generate
        if ((WORD_WIDTH % HBUS_DATA_WIDTH) != 0 || WORD_WIDTH < HBUS_DATA_WIDTH) begin : g_bad_width
            $error("WORD_WIDTH must be an integer multiple of HBUS_DATA_WIDTH");
        end
        if (NCH < 1 || NCH > 8) begin : g_bad_nch
            $error("NCH must be in 1..8");
        end
    endgenerate

    hbus_state_e                state_r, state_nxt_s;
    logic [PTR_W-1:0]           rr_ptr_r, ch_r, grant_idx_s;
    logic [NCH-1:0]             grant_s;
    logic                       grant_any_s, cmd_hs_s;
    logic [HBUS_ADDR_WIDTH-1:0] adr_r, sel_adr_s;
    logic [LEN_WIDTH-1:0]       sel_len_s;
    logic                       sel_we_s, sel_wvalid_s, sel_rready_s;
    logic [WORD_WIDTH-1:0]      sel_wdat_s;
    logic [BCNT_W-1:0]          bcnt_r;
    logic [WCNT_W-1:0]          words_left_r;
    logic [WORD_WIDTH-1:0]      sreg_r;
    logic                       sreg_valid_r;
    logic [CYC_W-1:0]           sreg_beats_r;
    logic                       wrq_r, rrq_r;
    logic [WORD_WIDTH-1:0]      asm_r, asm_next_s;
    logic [CYC_W-1:0]           asm_cnt_r;
    logic [WORD_WIDTH-1:0]      buf0_r, buf1_r;
    logic [1:0]                 buf_cnt_r;
    logic [NCH-1:0]             rd_overrun_r;
    logic                       last_beat_s, wr_beat_s, wr_room_s, wr_load_s;
    logic                       rd_beat_s, push_s, push_ok_s, drop_s, pop_s;
    logic [NCH-1:0]             cmd_ready_s, wr_ready_s, rd_valid_s, done_s;

    hyperbus_rr_arbiter #(
        .NCH   (NCH),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req       (cmd_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    assign sel_adr_s    = cmd_adr[grant_idx_s*HBUS_ADDR_WIDTH +: HBUS_ADDR_WIDTH];
    assign sel_len_s    = cmd_len[grant_idx_s*LEN_WIDTH +: LEN_WIDTH];
    assign sel_we_s     = cmd_we[grant_idx_s];
    assign sel_wdat_s   = wr_dat[ch_r*WORD_WIDTH +: WORD_WIDTH];
    assign sel_wvalid_s = wr_valid[ch_r];
    assign sel_rready_s = rd_ready[ch_r];

    assign cmd_hs_s    = (state_r == ST_IDLE) && !hbus_busy && grant_any_s;
    assign last_beat_s = (bcnt_r == BCNT_ONE);
    assign wr_beat_s   = (state_r == ST_WRITE) && wrq_r && sreg_valid_r && hbus_ready;
    // A new word fits when the register is empty or is losing its last beat now.
    assign wr_room_s   = (state_r == ST_WRITE) && (words_left_r != {WCNT_W{1'b0}}) &&
                         (!sreg_valid_r || (wr_beat_s && sreg_beats_r == CYC_ONE));
    assign wr_load_s   = wr_room_s && sel_wvalid_s;
    assign rd_beat_s   = (state_r == ST_READ) && rrq_r && hbus_valid;
    assign push_s      = rd_beat_s && (asm_cnt_r == CYC_LAST);
    assign pop_s       = (state_r == ST_READ) && (buf_cnt_r != 2'd0) && sel_rready_s;
    assign push_ok_s   = push_s && ((buf_cnt_r != 2'd2) || pop_s);
    assign drop_s      = push_s && !push_ok_s;
    assign asm_next_s  = WORD_WIDTH'(asm_r << HBUS_DATA_WIDTH) | WORD_WIDTH'(hbus_dat_i);

    // FSM state register.
    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; READ finishes once the buffer is (about to be) empty.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_hs_s) begin
                    state_nxt_s = (sel_we_s == CMD_WRITE) ? ST_WRITE : ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_beat_s && last_beat_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if ((bcnt_r == {BCNT_W{1'b0}}) &&
                    ((buf_cnt_r == 2'd0) || (buf_cnt_r == 2'd1 && pop_s))) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode; all per-channel strobes steer to the latched channel.
    always_comb begin
        cmd_ready_s = {NCH{1'b0}};
        wr_ready_s  = {NCH{1'b0}};
        rd_valid_s  = {NCH{1'b0}};
        done_s      = {NCH{1'b0}};
        if (state_r == ST_IDLE && !hbus_busy) begin
            cmd_ready_s = grant_s;
        end else begin
            cmd_ready_s = {NCH{1'b0}};
        end
        wr_ready_s[ch_r] = wr_room_s;
        rd_valid_s[ch_r] = (state_r == ST_READ) && (buf_cnt_r != 2'd0);
        done_s[ch_r]     = (state_r == ST_DONE);
    end

    assign cmd_ready  = cmd_ready_s;
    assign wr_ready   = wr_ready_s;
    assign rd_valid   = rd_valid_s;
    assign done       = done_s;
    assign rd_dat     = buf0_r;
    assign rd_overrun = rd_overrun_r;
    assign hbus_adr_o = adr_r;
    assign hbus_dat_o = sreg_r[WORD_WIDTH-1 -: HBUS_DATA_WIDTH];
    assign hbus_rrq   = rrq_r;
    assign hbus_wrq   = wrq_r;

    // Command latch, beat/word counters and bus request flags.
    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            rr_ptr_r     <= {PTR_W{1'b0}};
            ch_r         <= {PTR_W{1'b0}};
            adr_r        <= {HBUS_ADDR_WIDTH{1'b0}};
            bcnt_r       <= {BCNT_W{1'b0}};
            words_left_r <= {WCNT_W{1'b0}};
            wrq_r        <= 1'b0;
            rrq_r        <= 1'b0;
        end else if (cmd_hs_s) begin
            ch_r         <= grant_idx_s;
            adr_r        <= sel_adr_s;
            bcnt_r       <= BCNT_W'((int'(sel_len_s) + 1) * CYCLES);
            words_left_r <= WCNT_W'(int'(sel_len_s) + 1);
            rr_ptr_r     <= (grant_idx_s == PTR_LAST) ? {PTR_W{1'b0}} : grant_idx_s + PTR_ONE;
            wrq_r        <= (sel_we_s == CMD_WRITE);
            rrq_r        <= (sel_we_s == CMD_READ);
        end else begin
            if (wr_beat_s || rd_beat_s) begin
                bcnt_r <= bcnt_r - BCNT_ONE;
            end
            if (wr_beat_s && last_beat_s) begin
                wrq_r <= 1'b0;
            end
            if (rd_beat_s && last_beat_s) begin
                rrq_r <= 1'b0;
            end
            if (wr_load_s) begin
                words_left_r <= words_left_r - WCNT_ONE;
            end
        end
    end

    // Write serialiser: MSB-first beats, a load may coincide with the last shift.
    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            sreg_r       <= {WORD_WIDTH{1'b0}};
            sreg_valid_r <= 1'b0;
            sreg_beats_r <= {CYC_W{1'b0}};
        end else if (cmd_hs_s) begin
            sreg_valid_r <= 1'b0;
        end else if (wr_load_s) begin
            sreg_r       <= sel_wdat_s;
            sreg_valid_r <= 1'b1;
            sreg_beats_r <= CYC_W'(CYCLES);
        end else if (wr_beat_s) begin
            sreg_r       <= sreg_r << HBUS_DATA_WIDTH;
            sreg_beats_r <= sreg_beats_r - CYC_ONE;
            sreg_valid_r <= (sreg_beats_r != CYC_ONE);
        end
    end

    // Read assembler and 2-entry output buffer; overflowing words are dropped.
    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            asm_r        <= {WORD_WIDTH{1'b0}};
            asm_cnt_r    <= {CYC_W{1'b0}};
            buf0_r       <= {WORD_WIDTH{1'b0}};
            buf1_r       <= {WORD_WIDTH{1'b0}};
            buf_cnt_r    <= 2'd0;
            rd_overrun_r <= {NCH{1'b0}};
        end else if (cmd_hs_s) begin
            asm_cnt_r <= {CYC_W{1'b0}};
            buf_cnt_r <= 2'd0;
        end else begin
            if (rd_beat_s) begin
                asm_r     <= asm_next_s;
                asm_cnt_r <= push_s ? {CYC_W{1'b0}} : asm_cnt_r + CYC_ONE;
            end
            if (drop_s) begin
                rd_overrun_r[ch_r] <= 1'b1;
            end
            case ({push_ok_s, pop_s})
                2'b10: begin
                    if (buf_cnt_r == 2'd0) begin
                        buf0_r <= asm_next_s;
                    end else begin
                        buf1_r <= asm_next_s;
                    end
                    buf_cnt_r <= buf_cnt_r + 2'd1;
                end
                2'b01: begin
                    buf0_r    <= buf1_r;
                    buf_cnt_r <= buf_cnt_r - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_r == 2'd1) begin
                        buf0_r <= asm_next_s;
                    end else begin
                        buf0_r <= buf1_r;
                        buf1_r <= asm_next_s;
                    end
                end
                default: begin
                    buf_cnt_r <= buf_cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_burst_arbiter.sv
// Directed self-checking bench for hyperbus_burst_arbiter (NCH=2, 32-bit words,
// 16-bit beats). Inputs change and outputs are sampled around the falling edge.
module tb_hyperbus_burst_arbiter;

    logic        hbus_clk = 1'b0;
    logic        hbus_rst;
    logic [1:0]  cmd_valid, cmd_ready, cmd_we;
    logic [63:0] cmd_adr;
    logic [15:0] cmd_len;
    logic [1:0]  wr_valid, wr_ready;
    logic [63:0] wr_dat;
    logic [1:0]  rd_valid, rd_ready;
    logic [31:0] rd_dat;
    logic [1:0]  done, rd_overrun;
    logic [31:0] hbus_adr_o;
    logic [15:0] hbus_dat_o, hbus_dat_i;
    logic        hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy;

    int checks   = 0;
    int failures = 0;
    int w;

    hyperbus_burst_arbiter dut (
        .hbus_clk   (hbus_clk),
        .hbus_rst   (hbus_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_dat     (wr_dat),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_dat     (rd_dat),
        .done       (done),
        .rd_overrun (rd_overrun),
        .hbus_adr_o (hbus_adr_o),
        .hbus_dat_o (hbus_dat_o),
        .hbus_dat_i (hbus_dat_i),
        .hbus_rrq   (hbus_rrq),
        .hbus_wrq   (hbus_wrq),
        .hbus_ready (hbus_ready),
        .hbus_valid (hbus_valid),
        .hbus_busy  (hbus_busy)
    );

    always #5 hbus_clk = ~hbus_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-word write on one channel, beat by beat.
    task automatic do_write1(input int ch, input logic [31:0] adr, input logic [31:0] word,
                             input string tag);
        logic [1:0] oh;
        oh = 2'b01 << ch;
        cmd_valid = oh;
        cmd_we    = 2'b11;
        cmd_adr[ch*32 +: 32] = adr;
        cmd_len[ch*8 +: 8]   = 8'd0;
        wr_valid  = oh;
        wr_dat[ch*32 +: 32]  = word;
        hbus_ready = 1'b1;
        #1 chk({tag, "_cmd_ready"}, cmd_ready, oh);
        @(negedge hbus_clk);
        cmd_valid = 2'b00;
        chk({tag, "_wrq_up"}, hbus_wrq, 1'b1);
        chk({tag, "_adr"}, hbus_adr_o, adr);
        chk({tag, "_wr_ready"}, wr_ready, oh);
        @(negedge hbus_clk);
        wr_valid = 2'b00;
        chk({tag, "_beat1"}, hbus_dat_o, word[31:16]);
        chk({tag, "_wr_ready_off"}, wr_ready, 2'b00);
        @(negedge hbus_clk);
        chk({tag, "_beat2"}, hbus_dat_o, word[15:0]);
        chk({tag, "_wrq_hold"}, {hbus_wrq, done}, 3'b100);
        @(negedge hbus_clk);
        chk({tag, "_wrq_drop_done"}, {hbus_wrq, done}, {1'b0, oh});
        @(negedge hbus_clk);
        chk({tag, "_done_once"}, done, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hbus_rst = 1'b1;
        cmd_valid = 2'b00; cmd_we = 2'b00; cmd_adr = 64'd0; cmd_len = 16'd0;
        wr_valid = 2'b00; wr_dat = 64'd0; rd_ready = 2'b00;
        hbus_dat_i = 16'd0; hbus_ready = 1'b0; hbus_valid = 1'b0; hbus_busy = 1'b0;
        repeat (2) @(negedge hbus_clk);
        hbus_rst = 1'b0;
        #1;
        chk("reset_outs", {hbus_rrq, hbus_wrq, done, rd_valid, rd_overrun, cmd_ready, wr_ready}, 12'd0);
        chk("reset_adr_dat", {hbus_adr_o, hbus_dat_o}, 48'd0);
        @(negedge hbus_clk);

        // Single write ch0.
        do_write1(0, 32'h0000_0100, 32'hA5A5_1234, "wr1");

        // Read burst ch1, len 3, immediate drain.
        cmd_valid = 2'b10; cmd_we = 2'b00; cmd_adr[63:32] = 32'h0000_0200; cmd_len[15:8] = 8'd3;
        rd_ready = 2'b10;
        #1 chk("rd_cmd_ready", cmd_ready, 2'b10);
        @(negedge hbus_clk);
        cmd_valid = 2'b00;
        chk("rd_rrq_adr", {hbus_rrq, hbus_adr_o}, {1'b1, 32'h0000_0200});
        for (int i = 1; i <= 8; i++) begin
            hbus_valid = 1'b1;
            hbus_dat_i = 16'(i);
            @(negedge hbus_clk);
            if ((i % 2) == 0) begin
                chk("rd_valid_word", rd_valid, 2'b10);
                chk("rd_dat_word", rd_dat, 64'((i - 1) * 65536 + i));
            end else begin
                chk("rd_valid_gap", rd_valid, 2'b00);
            end
        end
        hbus_valid = 1'b0;
        chk("rd_rrq_drop", hbus_rrq, 1'b0);
        @(negedge hbus_clk);
        chk("rd_done", {done, rd_valid, rd_overrun}, {2'b10, 2'b00, 2'b00});
        @(negedge hbus_clk);
        chk("rd_done_once", done, 2'b00);
        rd_ready = 2'b00;

        // Busy blocks arbitration, then round-robin between both channels.
        hbus_busy = 1'b1;
        cmd_valid = 2'b11; cmd_we = 2'b11; cmd_len = 16'd0;
        wr_valid = 2'b11; wr_dat = {32'h2222_AAAA, 32'h1111_5555};
        repeat (3) begin
            #1 chk("busy_no_ready", {cmd_ready, hbus_wrq, hbus_rrq}, 4'b0000);
            @(negedge hbus_clk);
        end
        hbus_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            w = 0;
            while (cmd_ready == 2'b00 && w < 20) begin
                @(negedge hbus_clk);
                #1;
                w++;
            end
            chk("rr_grant", cmd_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge hbus_clk);
            @(negedge hbus_clk);
            chk("rr_beat1", hbus_dat_o, (k % 2 == 0) ? 16'h1111 : 16'h2222);
            w = 0;
            @(negedge hbus_clk);
            while (done == 2'b00 && w < 20) begin
                @(negedge hbus_clk);
                w++;
            end
            chk("rr_done", done, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        cmd_valid = 2'b00; wr_valid = 2'b00;
        @(negedge hbus_clk);

        // Read len 3 on ch0 with no drain: two buffered, two dropped.
        cmd_valid = 2'b01; cmd_we = 2'b00; cmd_adr[31:0] = 32'h0000_0500; cmd_len[7:0] = 8'd3;
        #1 chk("ovr_cmd_ready", cmd_ready, 2'b01);
        @(negedge hbus_clk);
        cmd_valid = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            hbus_valid = 1'b1;
            hbus_dat_i = 16'(16 + i);
            @(negedge hbus_clk);
        end
        hbus_valid = 1'b0;
        chk("ovr_flags", {rd_overrun, rd_valid, hbus_rrq}, 5'b01_01_0);
        chk("ovr_head1", rd_dat, 32'h0011_0012);
        repeat (2) begin
            @(negedge hbus_clk);
            chk("ovr_wait_no_done", {done, rd_valid}, 4'b00_01);
        end
        rd_ready = 2'b01;
        @(negedge hbus_clk);
        chk("ovr_head2", rd_dat, 32'h0013_0014);
        chk("ovr_not_done_yet", {done, rd_valid}, 4'b00_01);
        @(negedge hbus_clk);
        chk("ovr_done", {done, rd_valid}, 4'b01_00);
        rd_ready = 2'b00;
        @(negedge hbus_clk);

        // Write len 1 on ch1 with a 3-cycle gap between words.
        cmd_valid = 2'b10; cmd_we = 2'b10; cmd_adr[63:32] = 32'h0000_0300; cmd_len[15:8] = 8'd1;
        wr_valid = 2'b10; wr_dat[63:32] = 32'hDEAD_BEEF; hbus_ready = 1'b1;
        #1 chk("gap_cmd_ready", cmd_ready, 2'b10);
        @(negedge hbus_clk);
        cmd_valid = 2'b00;
        chk("gap_wr_ready", wr_ready, 2'b10);
        @(negedge hbus_clk);
        wr_valid = 2'b00;
        chk("gap_beat1", hbus_dat_o, 16'hDEAD);
        @(negedge hbus_clk);
        chk("gap_beat2", hbus_dat_o, 16'hBEEF);
        chk("gap_ready_on_last", wr_ready, 2'b10);
        repeat (3) begin
            @(negedge hbus_clk);
            chk("gap_wrq_hold", {hbus_wrq, done}, 3'b100);
        end
        wr_valid = 2'b10; wr_dat[63:32] = 32'hCAFE_F00D;
        @(negedge hbus_clk);
        wr_valid = 2'b00;
        chk("gap_beat3", {hbus_wrq, hbus_dat_o}, {1'b1, 16'hCAFE});
        @(negedge hbus_clk);
        chk("gap_beat4", {hbus_wrq, hbus_dat_o, wr_ready}, {1'b1, 16'hF00D, 2'b00});
        @(negedge hbus_clk);
        chk("gap_done", {hbus_wrq, done}, 3'b010);
        @(negedge hbus_clk);

        // Reset in the middle of a read burst, then a fresh write.
        cmd_valid = 2'b01; cmd_we = 2'b00; cmd_adr[31:0] = 32'h0000_0600; cmd_len[7:0] = 8'd3;
        rd_ready = 2'b01;
        #1 chk("rst_cmd_ready", cmd_ready, 2'b01);
        @(negedge hbus_clk);
        cmd_valid = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            hbus_valid = 1'b1;
            hbus_dat_i = 16'(i);
            @(negedge hbus_clk);
        end
        hbus_valid = 1'b0;
        hbus_rst = 1'b1;
        #1;
        chk("rst_mid_rrq", hbus_rrq, 1'b0);
        chk("rst_mid_outs", {done, rd_valid, rd_overrun, hbus_adr_o}, 38'd0);
        repeat (2) begin
            @(negedge hbus_clk);
            chk("rst_no_done", done, 2'b00);
        end
        hbus_rst = 1'b0;
        rd_ready = 2'b00;
        @(negedge hbus_clk);
        chk("rst_after", {done, hbus_rrq, hbus_wrq}, 4'b0000);
        do_write1(0, 32'h0000_0700, 32'h1357_2468, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
